// File: rtl/pid_pwm_driver_if.sv
// Duty-value handshake between pid_controller (master) and pid_pwm_driver (slave).
interface pid_pwm_driver_if;
  logic       ctrl_valid;
  logic [7:0] ctrl_in;
  logic       ctrl_ready;

  modport master (output ctrl_valid, output ctrl_in, input ctrl_ready);
  modport slave  (input ctrl_valid, input ctrl_in, output ctrl_ready);
endinterface

// File: rtl/pid_pwm_driver.sv
// PID output stage: shadowed 8-bit duty applied at PWM period boundaries, 256-tick period.
// Optional macro PWM_SLEW_EN limits the duty change per boundary to SLEW_STEP.
module pid_pwm_driver #(
  parameter int PRESCALE  = 4,
  parameter int SLEW_STEP = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  pid_pwm_driver_if.slave        ctrl,
  output logic                   pwm_out,
  output logic                   period_start,
  output logic [7:0]             duty_active
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);

  generate
    if (PRESCALE < 1 || SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_param_check
      $error("pid_pwm_driver: PRESCALE must be >=1 and SLEW_STEP 1..255");
    end
  endgenerate

  state_t          state_r;
  logic [PW-1:0]   presc_r;
  logic [7:0]      cnt_r;
  logic [7:0]      duty_shadow_r;
  logic [7:0]      duty_active_r;
  logic            pending_r;
  logic            pwm_out_r;
  logic            period_start_r;

  logic            tick_s;
  logic            wrap_s;
  logic            entry_s;
  logic            boundary_s;
  logic            accept_s;
  logic            run_hold_s;
  logic [7:0]      duty_next_s;

`ifdef PWM_SLEW_EN
  localparam logic [7:0] SLEW_C = 8'(SLEW_STEP);
  logic [7:0]      diff_s;
`endif

  // Tick/boundary decode and the duty value a boundary would apply.
  always_comb begin
    run_hold_s  = (state_r == RUN) && enable;
    tick_s      = (state_r == RUN) && (presc_r == PRESC_MAX);
    wrap_s      = run_hold_s && tick_s && (cnt_r == 8'd255);
    entry_s     = (state_r == IDLE) && enable;
    boundary_s  = wrap_s || entry_s;
    accept_s    = ctrl.ctrl_valid && !pending_r;
`ifdef PWM_SLEW_EN
    diff_s      = 8'd0;
    duty_next_s = duty_active_r;
    if (duty_shadow_r > duty_active_r) begin
      diff_s = duty_shadow_r - duty_active_r;
      if (diff_s > SLEW_C) begin
        duty_next_s = duty_active_r + SLEW_C;
      end else begin
        duty_next_s = duty_shadow_r;
      end
    end else if (duty_shadow_r < duty_active_r) begin
      diff_s = duty_active_r - duty_shadow_r;
      if (diff_s > SLEW_C) begin
        duty_next_s = duty_active_r - SLEW_C;
      end else begin
        duty_next_s = duty_shadow_r;
      end
    end else begin
      duty_next_s = duty_shadow_r;
    end
`else
    duty_next_s = duty_shadow_r;
`endif
  end

  // FSM, prescaler/counter, handshake state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      presc_r        <= '0;
      cnt_r          <= 8'd0;
      duty_shadow_r  <= 8'd0;
      duty_active_r  <= 8'd0;
      pending_r      <= 1'b0;
      pwm_out_r      <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      state_r <= enable ? RUN : IDLE;

      // Dropping enable abandons the period: counters restart from 0 on re-entry.
      if (run_hold_s) begin
        if (tick_s) begin
          presc_r <= '0;
          cnt_r   <= cnt_r + 8'd1;
        end else begin
          presc_r <= presc_r + PW'(1);
        end
      end else begin
        presc_r <= '0;
        cnt_r   <= 8'd0;
      end

      pwm_out_r      <= run_hold_s && (cnt_r < duty_active_r);
      period_start_r <= boundary_s;

      if (accept_s) begin
        duty_shadow_r <= ctrl.ctrl_in;
      end

      if (boundary_s && pending_r) begin
        duty_active_r <= duty_next_s;
      end

      // Accept only happens while not pending, so the two branches never collide.
      if (accept_s) begin
        pending_r <= 1'b1;
      end else if (boundary_s && pending_r && (duty_next_s == duty_shadow_r)) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign ctrl.ctrl_ready = !pending_r;
  assign pwm_out         = pwm_out_r;
  assign period_start    = period_start_r;
  assign duty_active     = duty_active_r;

endmodule

// File: doc/pid_pwm_driver.md
# pid_pwm_driver

Downstream stage of the PID controller: accepts the 8-bit control signal through a valid/ready handshake and converts it into a single-ended PWM waveform for the actuator. The new duty value goes into a shadow register and is applied only at PWM period boundaries, so the output never glitches mid-period. Sits between `pid_controller` and the top-level output pins.

## Interface
- `PRESCALE`, default 4: clk cycles per PWM counter tick, ≥1.
- `SLEW_STEP`, default 8: maximum duty change per period, used only with `PWM_SLEW_EN`, 1..255.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: run PWM when high; hold in IDLE when low.
- `ctrl_valid` input 1: `ctrl_in` is valid.
- `ctrl_in` input 8: requested duty, unsigned, 0..255.
- `ctrl_ready` output 1: block can accept a new duty value.
- `pwm_out` output 1: registered PWM output.
- `period_start` output 1: one-cycle pulse at the start of each PWM period.
- `duty_active` output 8: duty currently applied.

## Operation
- States: IDLE and RUN.
  - IDLE → RUN when `enable`=1.
  - RUN → IDLE when `enable`=0, evaluated every cycle; a period in progress is abandoned.
- In IDLE:
  - Prescaler and counter are held at 0.
  - `pwm_out`=0 and `period_start`=0.
  - Handshake stays active.
- Prescaler counts 0..PRESCALE-1. A tick occurs on the cycle the prescaler equals PRESCALE-1, after which it wraps to 0.
- The 8-bit counter advances on each tick and wraps 255→0, giving a period of 256 ticks.
- `pwm_out` is registered: `pwm_out` <= (state==RUN) && (cnt < `duty_active`).
  - Duty 0 keeps the output low for the whole period.
  - Duty 255 drives it high for 255 of 256 ticks.
- Handshake:
  - `ctrl_ready` = !pending.
  - Transfer occurs when `ctrl_valid` && `ctrl_ready`: `ctrl_in` goes into `duty_shadow` and pending is set.
  - `ctrl_valid` while not ready is ignored; the source must hold it.
- Boundary event:
  - Occurs at the tick where cnt==255 (the wrap), and on the IDLE→RUN entry cycle.
  - If pending: `duty_active` is updated from `duty_shadow`, and pending clears once `duty_active`==`duty_shadow`.
  - If not pending: no change.
- Accept and boundary in the same cycle: the accepted value lands in the shadow and is applied at the next boundary, not this one.
- Reset clears: state=IDLE, prescaler=0, cnt=0, `duty_shadow`=0, `duty_active`=0, pending=0.

## Timing
- Reset values: `pwm_out`=0, `period_start`=0, `duty_active`=0, `ctrl_ready`=1.
- `ctrl_ready` deasserts in the cycle after an accept.
- `ctrl_ready` reasserts in the cycle after the boundary that clears pending.
- `duty_active` updates one cycle after the boundary event.
- `pwm_out` lags cnt/`duty_active` by one cycle.
- `period_start`:
  - Registered, high for exactly one cycle, coincident with the first cycle where cnt==0 in a RUN period.
  - This includes the first cycle after IDLE→RUN.
- Period length is 256×PRESCALE clk cycles.
- `enable` falling: `pwm_out`=0 from the next cycle; cnt=0 from the next cycle.
- Asynchronous reset mid-period: all outputs take their reset values immediately; pending data is lost.

## Configuration
- `PWM_SLEW_EN` defined:
  - At each boundary with pending, `duty_active` moves toward `duty_shadow` by min(|diff|, SLEW_STEP).
  - pending, and therefore `ctrl_ready`=0, persists until `duty_active`==`duty_shadow`. Large steps take multiple periods.
- `PWM_SLEW_EN` undefined: `duty_active` <= `duty_shadow` in one boundary; `SLEW_STEP` is unused.

## Test plan
- Reset default: assert `rst_n`=0 mid-run → `pwm_out`=0, `duty_active`=0, `ctrl_ready`=1, `period_start`=0 immediately.
- Basic duty: PRESCALE=1, `enable`=1, send `ctrl_in`=64 → applied at entry boundary; thereafter `pwm_out` high 64 cycles then low 192 cycles per 256-cycle period; `period_start` every 256 cycles.
- Extremes: duty 0 → `pwm_out` never high; duty 255 → exactly 1 low cycle per period.
- Glitch-free update: mid-period (cnt=100, duty=64) accept 200 → `ctrl_ready`=0 until the wrap; current period stays at 64 high, next period is 200 high; a second `ctrl_valid` during pending is ignored.
- Enable drop: deassert `enable` at cnt=30 with duty=128 → `pwm_out`=0 the next cycle, cnt=0; re-enable → `period_start` pulse on the first cnt==0 cycle.
- With `PWM_SLEW_EN`, SLEW_STEP=8, `duty_active`=0, accept 20 → `duty_active` 8, 16, 20 over three consecutive boundaries; `ctrl_ready` returns high after the third.
